reg_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters.
  - Requester A: the main pipeline writeback.
  - Requester B: the multi-cycle unit / load return path.
- Each requester has a one-entry holding buffer and a valid/ready handshake.
- Writes are issued oldest-first, and the result is registered into the register file's RegWrite / WriteRegister / WriteData inputs.
- It also exports a pending-write mask so hazard logic can stall readers of registers with uncommitted writes.

---
 rtl/reg_write_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register file write port between the main
// pipeline writeback (A) and the multi-cycle / load return path (B).
// Each side has a one-entry holding buffer; writes leave oldest-first through
// a registered RegWrite / WriteRegister / WriteData stage, and busy_mask flags
// every register with an accepted but not yet committed write.
module reg_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       busy_mask
);

  // Holding buffers
  logic              r_a_full;
  logic [ADDR_W-1:0] r_a_addr;
  logic [DATA_W-1:0] r_a_data;
  logic              r_b_full;
  logic [ADDR_W-1:0] r_b_addr;
  logic [DATA_W-1:0] r_b_data;
  // Age bit: 1 when bufA holds the older write (only meaningful if both full)
  logic              r_a_older;
  // Output stage towards the register file
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_register;
  logic [DATA_W-1:0] r_write_data;

  logic        w_a_win;
  logic        w_b_win;
  logic        w_a_load;
  logic        w_b_load;
  logic        w_a_stays;
  logic        w_b_stays;
  logic [31:0] w_busy;

  // Winner selection and ready: purely from registered buffer state.
  assign w_a_win = r_a_full & (~r_b_full | r_a_older);
  assign w_b_win = r_b_full & (~r_a_full | ~r_a_older);
  assign a_ready = ~r_a_full | w_a_win;
  assign b_ready = ~r_b_full | w_b_win;

  // A handshake to register 0 is consumed but never buffered.
  assign w_a_load  = a_valid & a_ready & (a_addr != '0);
  assign w_b_load  = b_valid & b_ready & (b_addr != '0);
  // A buffer that is full and not draining this edge keeps its entry.
  assign w_a_stays = r_a_full & ~w_a_win;
  assign w_b_stays = r_b_full & ~w_b_win;

  // Buffer, age and output-stage state update.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: buffer payloads are reset along with their full bits; they are
      // only a few flops and this keeps WriteRegister/WriteData deterministic.
      r_a_full         <= 1'b0;
      r_a_addr         <= '0;
      r_a_data         <= '0;
      r_b_full         <= 1'b0;
      r_b_addr         <= '0;
      r_b_data         <= '0;
      r_a_older        <= 1'b1;
      r_reg_write      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
    end else begin
      r_a_full <= w_a_load | w_a_stays;
      r_b_full <= w_b_load | w_b_stays;
      if (w_a_load) begin
        r_a_addr <= a_addr;
        r_a_data <= a_data;
      end
      if (w_b_load) begin
        r_b_addr <= b_addr;
        r_b_data <= b_data;
      end

      // The newcomer is younger than an entry that stays; a same-edge tie
      // into otherwise free buffers goes to A.
      if (w_a_load && w_b_stays) begin
        r_a_older <= 1'b0;
      end else if (w_b_load && w_a_stays) begin
        r_a_older <= 1'b1;
      end else if (w_a_load && w_b_load) begin
        r_a_older <= 1'b1;
      end

      if (w_a_win) begin
        r_reg_write      <= 1'b1;
        r_write_register <= r_a_addr;
        r_write_data     <= r_a_data;
      end else if (w_b_win) begin
        r_reg_write      <= 1'b1;
        r_write_register <= r_b_addr;
        r_write_data     <= r_b_data;
      end else begin
        r_reg_write <= 1'b0;
      end
    end
  end

  // Pending-write mask: buffered entries plus the write being committed.
  always_comb begin
    // NOTE: default first so every path assigns w_busy and no latch forms.
    w_busy = '0;
    for (int i = 0; i < 32; i++) begin
      if ((r_a_full && r_a_addr == ADDR_W'(i)) ||
          (r_b_full && r_b_addr == ADDR_W'(i)) ||
          (r_reg_write && r_write_register == ADDR_W'(i))) begin
        w_busy[i] = 1'b1;
      end
    end
  end

  assign RegWrite      = r_reg_write;
  assign WriteRegister = r_write_register;
  assign WriteData     = r_write_data;
  assign busy_mask     = w_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: per-cycle vector table for the directed
// scenarios, a sustained dual-load stream, a mid-operation reset, and a
// scoreboard that matches every committed write against the expected order.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] busy_mask;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ear;
    logic        ebr;
    logic        erw;
    logic [31:0] ebusy;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  writes = 0;

  reg_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .busy_mask    (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int av, input int aa, input int ad,
                              input int bv, input int ba, input int bd,
                              input int ear, input int ebr, input int erw,
                              input int ebusy);
    vec_t v;
    v.av    = av[0];
    v.aa    = aa[4:0];
    v.ad    = ad;
    v.bv    = bv[0];
    v.ba    = ba[4:0];
    v.bd    = bd;
    v.ear   = ear[0];
    v.ebr   = ebr[0];
    v.erw   = erw[0];
    v.ebusy = ebusy;
    return v;
  endfunction

  function automatic wr_t mkw(input logic [4:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

  // Scoreboard: every committed write must be the next one expected.
  always @(negedge clk) begin
    if (rst_n && RegWrite) begin
      writes++;
      if (exp_q.size() == 0) begin
        check("unexpected commit addr", 32'(WriteRegister), 32'h0);
        check("unexpected commit occurred", 32'(RegWrite), 32'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("commit addr", 32'(WriteRegister), 32'(e.addr));
        check("commit data", WriteData, e.data);
      end
    end
  end

  initial begin
    vec_t vecs[17];
    int   ia;
    int   ib;

    // av aa ad        bv ba bd    ar br rw busy
    vecs[0]  = mk(1, 5, 32'hAA, 0, 0, 0,    1, 1, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0,      0, 0, 0,    1, 1, 0, 32'h20);
    vecs[2]  = mk(0, 0, 0,      0, 0, 0,    1, 1, 1, 32'h20);
    vecs[3]  = mk(0, 0, 0,      0, 0, 0,    1, 1, 0, 32'h0);
    vecs[4]  = mk(1, 3, 1,      1, 4, 2,    1, 1, 0, 32'h0);
    vecs[5]  = mk(0, 0, 0,      0, 0, 0,    1, 0, 0, 32'h18);
    vecs[6]  = mk(0, 0, 0,      0, 0, 0,    1, 1, 1, 32'h18);
    vecs[7]  = mk(0, 0, 0,      0, 0, 0,    1, 1, 1, 32'h10);
    vecs[8]  = mk(0, 0, 0,      0, 0, 0,    1, 1, 0, 32'h0);
    vecs[9]  = mk(0, 0, 0,      1, 7, 32'h11, 1, 1, 0, 32'h0);
    vecs[10] = mk(1, 7, 32'h22, 0, 0, 0,    1, 1, 0, 32'h80);
    vecs[11] = mk(0, 0, 0,      0, 0, 0,    1, 1, 1, 32'h80);
    vecs[12] = mk(0, 0, 0,      0, 0, 0,    1, 1, 1, 32'h80);
    vecs[13] = mk(0, 0, 0,      0, 0, 0,    1, 1, 0, 32'h0);
    vecs[14] = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 1, 0, 32'h0);
    vecs[15] = mk(0, 0, 0,      0, 0, 0,    1, 1, 0, 32'h0);
    vecs[16] = mk(0, 0, 0,      0, 0, 0,    1, 1, 0, 32'h0);

    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_addr  = '0;
    a_data  = '0;
    b_valid = 1'b0;
    b_addr  = '0;
    b_data  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset RegWrite", 32'(RegWrite), 32'h0);
    check("reset WriteRegister", 32'(WriteRegister), 32'h0);
    check("reset WriteData", WriteData, 32'h0);
    check("reset busy_mask", busy_mask, 32'h0);
    check("reset a_ready", 32'(a_ready), 32'h1);
    check("reset b_ready", 32'(b_ready), 32'h1);
    rst_n = 1'b1;

    // Directed vector table, one row per cycle
    for (int r = 0; r < 17; r++) begin
      a_valid = vecs[r].av;
      a_addr  = vecs[r].aa;
      a_data  = vecs[r].ad;
      b_valid = vecs[r].bv;
      b_addr  = vecs[r].ba;
      b_data  = vecs[r].bd;
      @(negedge clk);
      check($sformatf("row%0d a_ready", r), 32'(a_ready), 32'(vecs[r].ear));
      check($sformatf("row%0d b_ready", r), 32'(b_ready), 32'(vecs[r].ebr));
      check($sformatf("row%0d RegWrite", r), 32'(RegWrite), 32'(vecs[r].erw));
      check($sformatf("row%0d busy_mask", r), busy_mask, vecs[r].ebusy);
      if (vecs[r].av && vecs[r].ear && vecs[r].aa != 5'd0)
        exp_q.push_back(mkw(vecs[r].aa, vecs[r].ad));
      if (vecs[r].bv && vecs[r].ebr && vecs[r].ba != 5'd0)
        exp_q.push_back(mkw(vecs[r].ba, vecs[r].bd));
      @(posedge clk);
      #1;
    end

    // Sustained dual load: both sides offer addresses 1..8 back to back.
    // Both accepted in cycle 0, then A is ready on odd and B on even cycles.
    ia = 1;
    ib = 1;
    for (int c = 0; c < 20; c++) begin
      logic ear;
      logic ebr;
      a_valid = (ia <= 8);
      a_addr  = 5'(ia);
      a_data  = 32'hA000_0000 | 32'(ia);
      b_valid = (ib <= 8);
      b_addr  = 5'(ib);
      b_data  = 32'hB000_0000 | 32'(ib);
      ear = (c == 0) || (c % 2 == 1);
      ebr = (c == 0) || (c % 2 == 0);
      @(negedge clk);
      if (a_valid) check($sformatf("sustain c%0d a_ready", c), 32'(a_ready), 32'(ear));
      if (b_valid) check($sformatf("sustain c%0d b_ready", c), 32'(b_ready), 32'(ebr));
      check($sformatf("sustain c%0d RegWrite", c), 32'(RegWrite),
            32'((c >= 2 && c <= 17) ? 1 : 0));
      if (a_valid && ear) begin
        exp_q.push_back(mkw(a_addr, a_data));
        ia++;
      end
      if (b_valid && ebr) begin
        exp_q.push_back(mkw(b_addr, b_data));
        ib++;
      end
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;

    // Reset in cycle 1 after A and B have both been accepted
    a_valid = 1'b1;
    a_addr  = 5'd3;
    a_data  = 32'h33;
    b_valid = 1'b1;
    b_addr  = 5'd4;
    b_data  = 32'h44;
    @(negedge clk);
    check("rst-mid a_ready c0", 32'(a_ready), 32'h1);
    check("rst-mid b_ready c0", 32'(b_ready), 32'h1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("rst-mid busy before reset", busy_mask, 32'h18);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst-mid RegWrite", 32'(RegWrite), 32'h0);
    check("rst-mid WriteRegister", 32'(WriteRegister), 32'h0);
    check("rst-mid WriteData", WriteData, 32'h0);
    check("rst-mid busy_mask", busy_mask, 32'h0);
    check("rst-mid a_ready", 32'(a_ready), 32'h1);
    check("rst-mid b_ready", 32'(b_ready), 32'h1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post-rst c%0d RegWrite", k), 32'(RegWrite), 32'h0);
      check($sformatf("post-rst c%0d busy_mask", k), busy_mask, 32'h0);
      check($sformatf("post-rst c%0d a_ready", k), 32'(a_ready), 32'h1);
      check($sformatf("post-rst c%0d b_ready", k), 32'(b_ready), 32'h1);
    end

    // Everything expected was committed, exactly once
    check("scoreboard leftover", 32'(exp_q.size()), 32'h0);
    check("total commits", 32'(writes), 32'd21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
